// File: rtl/arduino_hub_pkg.sv
// Shared types and helpers for the Arduino hub endpoint: TX state encoding, frame sizing
// and the reserved broadcast address.
package arduino_hub_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SEND} tx_state_t;

  localparam int DROP_CNT_W = 8;

  // The all-ones address is reserved for broadcast and never assigned to a node.
  function automatic int broadcast_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  function automatic int frame_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/hub_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head whenever empty is low.
// A push while full is accepted only if a pop happens in the same cycle.
module hub_sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arduino_hub_node.sv
// Arduino endpoint on the hub bus: samples in_data/btn_send each tick, queues frames, sends via req/gnt,
// and latches frames addressed to MY_ADDR. Define BROADCAST_RX_EN to also accept all-ones-address frames.
module arduino_hub_node
  import arduino_hub_pkg::*;
#(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 2,
  parameter int MY_ADDR    = 2,
  parameter int TICK_DIV   = 25000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clock50,
  input  logic                             reset,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             btn_send,
  output logic                             bus_req,
  input  logic                             bus_gnt,
  output logic [frame_w(ADDR_W, DATA_W)-1:0] bus_out,
  output logic                             bus_out_valid,
  input  logic [frame_w(ADDR_W, DATA_W)-1:0] bus_in,
  input  logic                             bus_in_valid,
  output logic [DATA_W-1:0]                arduino_response,
  output logic                             fifo_full,
  output logic [DROP_CNT_W-1:0]            drop_count
);

  localparam int FW    = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [ADDR_W-1:0] ADDR    = ADDR_W'(MY_ADDR);
  localparam logic [DATA_W-1:0] BTN_DAT = DATA_W'(MY_ADDR);

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [DATA_W-1:0] prev_in;
  logic              prev_btn;
  logic              data_push;
  logic              btn_push;
  logic              push;
  logic [DATA_W-1:0] push_dat;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              empty;
  logic [1:0]        drop_inc;
  logic [DROP_CNT_W:0] drop_sum;
  logic              rx_hit;
  tx_state_t         state;
  tx_state_t         state_nxt;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock50) begin
    if (reset) begin
      tick_cnt <= '0;
      prev_in  <= '0;
      prev_btn <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (tick) begin
        prev_in  <= in_data;
        prev_btn <= btn_send;
      end
    end
  end

  // Arduino data wins a same-tick collision with the button; the button frame is counted as dropped.
  assign data_push = tick && (in_data != '0) && (in_data != prev_in);
  assign btn_push  = tick && btn_send && !prev_btn;
  assign push      = data_push || btn_push;
  assign push_dat  = data_push ? in_data : BTN_DAT;

  hub_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock50),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_dat),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty)
  );

  assign drop_inc = {1'b0, push && fifo_full && !pop} + {1'b0, data_push && btn_push};
  assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W + 1)'(drop_inc);

  always_ff @(posedge clock50) begin
    if (reset) drop_count <= '0;
    else       drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clock50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) state_nxt = REQ;
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_nxt = SEND;
      end
      SEND: begin
        pop       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A reset cycle must not leak a request or a frame even though state is still REQ/SEND.
    if (reset) begin
      bus_req = 1'b0;
      pop     = 1'b0;
    end
  end

  assign bus_out_valid = (state == SEND) && !reset;

  // Head cannot change between grant and SEND, so the frame is captured on the grant.
  always_ff @(posedge clock50) begin
    if (reset)                        bus_out <= '0;
    else if (state == REQ && bus_gnt) bus_out <= {ADDR, head};
  end

`ifdef BROADCAST_RX_EN
  localparam logic [ADDR_W-1:0] BCAST = ADDR_W'(broadcast_addr(ADDR_W));
  assign rx_hit = bus_in_valid &&
                  ((bus_in[FW-1:DATA_W] == ADDR) || (bus_in[FW-1:DATA_W] == BCAST));
`else
  assign rx_hit = bus_in_valid && (bus_in[FW-1:DATA_W] == ADDR);
`endif

  always_ff @(posedge clock50) begin
    if (reset)       arduino_response <= '0;
    else if (rx_hit) arduino_response <= bus_in[DATA_W-1:0];
  end

endmodule
